// File: rtl/vram_scanout.sv
// vram_scanout: display-side consumer of the VRAM read port.
//
// Generates VGA timing (640x480 by default), walks a fixed image window and issues
// one VRAM read per window pixel. The returned 8-bit grayscale value drives rgb_out.
// hsync, vsync and blank_n are delayed so that they line up with rgb_out. Pixels
// outside the window display as black.
//
// Ports:
//   clk          pixel clock
//   reset        asynchronous, active-low reset
//   display_en   scan-out request, sampled only at frame start (h=0, v=0)
//   gpu_address  VRAM read address (registered, valid one cycle after the counter position)
//   vram_out     VRAM read data, valid RD_LAT cycles after gpu_address
//   rgb_out      pixel to DAC, RD_LAT+1 cycles after the counter position
//   hsync        horizontal sync, active-low
//   vsync        vertical sync, active-low
//   blank_n      high during the visible area
//   frame_done   one-cycle pulse aligned with the last visible pixel of an active frame
//
// Optional build macro VRAM_SCANOUT_BORDER_EN: draws a 1-pixel white ring just outside
// the image window while active. The ring issues no VRAM read.

`timescale 1ns / 1ps

module vram_scanout #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter int unsigned IMG_W     = 256,
    parameter int unsigned IMG_H     = 256,
    parameter int unsigned X0        = 192,
    parameter int unsigned Y0        = 112,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned RD_LAT    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        display_en,
    output logic [31:0] gpu_address,
    input  logic [7:0]  vram_out,
    output logic [7:0]  rgb_out,
    output logic        hsync,
    output logic        vsync,
    output logic        blank_n,
    output logic        frame_done
);

    localparam int unsigned H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW         = $clog2(H_TOTAL);
    localparam int unsigned VW         = $clog2(V_TOTAL);
    localparam int unsigned HS_START   = H_ACTIVE + H_FP;
    localparam int unsigned HS_END     = HS_START + H_SYNC;
    localparam int unsigned VS_START   = V_ACTIVE + V_FP;
    localparam int unsigned VS_END     = VS_START + V_SYNC;
    localparam bit          IMG_W_POW2 = (IMG_W & (IMG_W - 1)) == 0;
    localparam int unsigned IMG_W_LOG2 = $clog2(IMG_W);

    typedef enum logic {StIdle, StActive} state_e;

    state_e          state_q, state_d;
    logic [HW-1:0]   h_cnt_q, h_cnt_d;
    logic [VW-1:0]   v_cnt_q, v_cnt_d;
    logic [31:0]     addr_q, addr_d;

    logic [31:0]     h32, v32;
    logic [31:0]     row, col, row_off;
    logic            hs_raw, vs_raw, vis_raw, in_win, win_act, fd_raw, active;

    // Delay lines: bit 0 is loaded from the counter position, bit RD_LAT drives outputs.
    logic [RD_LAT:0] hs_pipe, vs_pipe, vis_pipe, win_pipe, fd_pipe;

    // Counters free-run in every state.
    always_comb begin
        h_cnt_d = h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (32'(h_cnt_q) == H_TOTAL - 1) begin
            h_cnt_d = '0;
            v_cnt_d = (32'(v_cnt_q) == V_TOTAL - 1) ? '0 : v_cnt_q + 1'b1;
        end
    end

    // Raw timing, computed at 32 bits to keep the comparisons width-clean.
    always_comb begin
        h32     = 32'(h_cnt_q);
        v32     = 32'(v_cnt_q);
        active  = (state_q == StActive);
        hs_raw  = !(h32 >= HS_START && h32 < HS_END);
        vs_raw  = !(v32 >= VS_START && v32 < VS_END);
        vis_raw = (h32 < H_ACTIVE) && (v32 < V_ACTIVE);
        in_win  = vis_raw && (h32 >= X0) && (h32 < X0 + IMG_W)
                          && (v32 >= Y0) && (v32 < Y0 + IMG_H);
        win_act = in_win && active;
        fd_raw  = active && (h32 == H_ACTIVE - 1) && (v32 == V_ACTIVE - 1);
    end

    // Mode changes only at frame start so a frame is never cut short.
    always_comb begin
        state_d = state_q;
        if (h_cnt_q == '0 && v_cnt_q == '0) begin
            unique case (state_q)
                StIdle:   if (display_en)  state_d = StActive;
                StActive: if (!display_en) state_d = StIdle;
                default:  state_d = StIdle;
            endcase
        end
    end

    // Linear address inside the window; holds its last value elsewhere.
    always_comb begin
        row = v32 - Y0;
        col = h32 - X0;
        if (IMG_W_POW2) begin
            row_off = row << IMG_W_LOG2;
        end else begin
            row_off = row * IMG_W;
        end
        addr_d = win_act ? (BASE_ADDR + row_off + col) : addr_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_cnt_q  <= '0;
            v_cnt_q  <= '0;
            state_q  <= StIdle;
            addr_q   <= BASE_ADDR;
            hs_pipe  <= '1;
            vs_pipe  <= '1;
            vis_pipe <= '0;
            win_pipe <= '0;
            fd_pipe  <= '0;
        end else begin
            h_cnt_q  <= h_cnt_d;
            v_cnt_q  <= v_cnt_d;
            state_q  <= state_d;
            addr_q   <= addr_d;
            hs_pipe  <= {hs_pipe[RD_LAT-1:0], hs_raw};
            vs_pipe  <= {vs_pipe[RD_LAT-1:0], vs_raw};
            vis_pipe <= {vis_pipe[RD_LAT-1:0], vis_raw};
            win_pipe <= {win_pipe[RD_LAT-1:0], win_act};
            fd_pipe  <= {fd_pipe[RD_LAT-1:0], fd_raw};
        end
    end

    assign gpu_address = addr_q;
    assign hsync       = hs_pipe[RD_LAT];
    assign vsync       = vs_pipe[RD_LAT];
    assign blank_n     = vis_pipe[RD_LAT];
    assign frame_done  = fd_pipe[RD_LAT];

`ifdef VRAM_SCANOUT_BORDER_EN
    logic            bd_raw;
    logic [RD_LAT:0] bd_pipe;

    // Ring = one-pixel-larger rectangle minus the window itself. h32 + 1 >= X0 avoids
    // an underflow when X0 is 0.
    always_comb begin
        bd_raw = active && vis_raw && !in_win
              && (h32 + 1 >= X0) && (h32 <= X0 + IMG_W)
              && (v32 + 1 >= Y0) && (v32 <= Y0 + IMG_H);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bd_pipe <= '0;
        end else begin
            bd_pipe <= {bd_pipe[RD_LAT-1:0], bd_raw};
        end
    end

    always_comb begin
        rgb_out = 8'h00;
        if (win_pipe[RD_LAT]) begin
            rgb_out = vram_out;
        end else if (bd_pipe[RD_LAT]) begin
            rgb_out = 8'hFF;
        end
    end
`else
    always_comb begin
        rgb_out = 8'h00;
        if (win_pipe[RD_LAT]) begin
            rgb_out = vram_out;
        end
    end
`endif

endmodule
